// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mul_pkg;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;
  localparam int MUL_LAST  = MUL_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/adder_32.sv
// 32-bit ripple adder with carry in/out; purely combinational, zero latency, no flow control.
module adder_32 (
  output logic [31:0] sum,
  output logic        cout,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin
);
  always_comb begin
    {cout, sum} = {1'b0, in1} + {1'b0, in2} + {32'b0, cin};
  end
endmodule

// File: rtl/mul_seq_32.sv
// 32x32->64 unsigned shift-add multiplier, one product bit per cycle; out_valid rises 33 cycles after accept.
// Operands are taken only in IDLE; the product is held stable until out_ready is seen.
module mul_seq_32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t         state_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  always_comb begin
    addend = p_q[0] ? a_q : '0;
  end

  adder_32 u_adder (
    .sum  (sum),
    .cout (cout),
    .in1  (p_q[2*WIDTH-1:WIDTH]),
    .in2  (addend),
    .cin  (1'b0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      p_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            p_q      <= {{WIDTH{1'b0}}, op_b};
            cnt_q    <= '0;
            state_q  <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Carry-out lands in the MSB after the shift, so the 64-bit P never overflows.
          p_q   <= {cout, sum, p_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            product   <= p_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32 with an expected-product queue.
module tb_mul_seq_32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [63:0] exp_q[$];

  mul_seq_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; acc_cyc marks the accept edge.
  task automatic do_accept(input logic [31:0] a, input logic [31:0] b, output logic ok);
    logic rdy;
    ok = 1'b0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int i = 0; i < 100; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, stall the consumer, then complete the handshake.
  task automatic wait_out(input int stalls, output logic ok, output logic [63:0] got);
    ok = 1'b0;
    got = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      for (int i = 0; i < stalls; i++) tick();
      out_ready = 1'b1;
      got = product;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (product !== 64'd0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
  endtask

  task automatic test_basic_latency();
    logic ok;
    logic [63:0] got;
    logic [63:0] exp;
    int lat;
    int high;
    lat = -1;
    high = 0;
    got = '0;
    do_accept(32'd7, 32'd6, ok);
    exp_q.push_back(64'd42);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", ok); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    out_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (out_valid) begin
        if (lat < 0) begin
          lat = cyc - acc_cyc;
          got = product;
        end
        high++;
      end
      tick();
    end
    out_ready = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL basic_product got=%h exp=%h", got, exp); end
    checks++; if (lat != 33) begin failures++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    checks++; if (high != 1) begin failures++; $display("FAIL basic_valid_width got=%0d exp=1", high); end
  endtask

  task automatic test_max();
    logic ok;
    logic [63:0] got;
    logic [63:0] exp;
    do_accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    wait_out(2, ok, got);
    exp = exp_q.pop_front();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL max_timeout got=%b exp=1", ok); end
    checks++; if (got !== exp) begin failures++; $display("FAIL max_product got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid_run();
    logic ok;
    logic seen;
    logic [63:0] got;
    logic [63:0] exp;
    do_accept(32'h1000, 32'h3, ok);
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (product !== 64'd0) begin failures++; $display("FAIL midrst_product got=%h exp=0", product); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | out_valid;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_output got=%b exp=0", seen); end
    do_accept(32'd5, 32'd9, ok);
    exp_q.push_back(64'd45);
    wait_out(1, ok, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL midrst_after got=%h exp=%h", got, exp); end
  endtask

  task automatic test_zero_backpressure();
    logic ok;
    logic [63:0] exp;
    logic [63:0] held;
    do_accept(32'd0, 32'h1234_5678, ok);
    exp_q.push_back(64'd0);
    out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", ok); end
    held = product;
    for (int k = 0; k < 10; k++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold cyc%0d got=%b exp=1", k, out_valid); end
      checks++; if (product !== 64'd0) begin failures++; $display("FAIL bp_product_hold cyc%0d got=%h exp=0", k, product); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", k, in_ready); end
      in_valid = k[0];
      op_a = $urandom;
      op_b = $urandom;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (held !== exp) begin failures++; $display("FAIL bp_product got=%h exp=%h", held, exp); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_return got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [63:0] got1;
    logic [63:0] got2;
    logic [63:0] exp;
    int valid_cyc;
    int ready_cyc;
    int state;
    do_accept(32'd3, 32'd4, ok);
    exp_q.push_back(64'd12);
    exp_q.push_back(64'd143);
    in_valid = 1'b1;
    op_a = 32'd11;
    op_b = 32'd13;
    out_ready = 1'b1;
    got1 = '0;
    got2 = '0;
    valid_cyc = -1;
    ready_cyc = -1;
    state = 0;
    for (int i = 0; i < 200 && state < 3; i++) begin
      case (state)
        0: if (out_valid) begin got1 = product; valid_cyc = cyc; state = 1; end
        1: if (in_ready) begin ready_cyc = cyc; state = 2; end
        default: if (out_valid) begin got2 = product; state = 3; end
      endcase
      tick();
      if (state == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++; if (state != 3) begin failures++; $display("FAIL b2b_timeout got=%0d exp=3", state); end
    exp = exp_q.pop_front();
    checks++; if (got1 !== exp) begin failures++; $display("FAIL b2b_first got=%h exp=%h", got1, exp); end
    exp = exp_q.pop_front();
    checks++; if (got2 !== exp) begin failures++; $display("FAIL b2b_second got=%h exp=%h", got2, exp); end
    checks++; if (ready_cyc - valid_cyc != 1) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=1", ready_cyc - valid_cyc); end
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic ok;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] got;
    logic [63:0] exp;
    int errs_before;
    errs_before = failures;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'd0;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'd1;
        default: ;
      endcase
      do_accept(a, b, ok);
      exp_q.push_back(64'(a) * 64'(b));
      wait_out(int'($urandom_range(0, 3)), ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        if (failures - errs_before < 10)
          $display("FAIL rand_%0d a=%h b=%h got=%h exp=%h", n, a, b, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_max();
    test_reset_mid_run();
    test_zero_backpressure();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
